// File: rtl/display_7seg_controller.sv
// display_7seg_controller: bus-mapped eight-digit 7-segment display controller.
// Registers: DATA (0x0), CTRL (0x4, bit0 = decimal mode), STATUS (0x8, bit0 busy,
// bit1 overflow), 0xC reserved. In hex mode DATA drives the digits directly.
// Optional feature macro: DISPLAY_7SEG_DECIMAL_EN. When it is defined, a
// double-dabble converter turns DATA into ten BCD digits. The low eight digits
// are shown, and any nonzero upper digit sets overflow. When the macro is
// undefined, the display always mirrors DATA and the CTRL/STATUS bits read 0.
module display_7seg_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [3:0]  address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] read_data,
  output logic [31:0] display_data,
  output logic        busy
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  logic [31:0] r_data;
  logic [31:0] r_display;
  logic [31:0] r_read_data;

  logic [1:0]  w_sel;
  logic        w_data_wr;
  logic        w_ctrl_wr;
  logic [31:0] w_data_merged;
  logic [31:0] w_read_mux;
  logic        w_mode;
  logic        w_overflow;
  logic        w_busy;
  logic        w_unused;

  // Only the word select matters; the byte offset bits are ignored.
  assign w_sel    = address[3:2];
  assign w_unused = ^address[1:0];

  // An all-zero byte mask is a no-op, so it is not treated as a DATA write.
  assign w_data_wr = write_enable && (w_sel == ADDR_DATA) && (write_mask != 4'b0000);
  assign w_ctrl_wr = write_enable && (w_sel == ADDR_CTRL) && write_mask[0];

  // Byte-wise merge of the incoming write over the current DATA value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    w_data_merged = r_data;
    for (int b = 0; b < 4; b++) begin
      if (write_mask[b]) begin
        w_data_merged[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

  // DATA register: updated on any DATA write with at least one enabled byte.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_data <= '0;
    end else if (w_data_wr) begin
      r_data <= w_data_merged;
    end
  end

`ifdef DISPLAY_7SEG_DECIMAL_EN

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_mode;
  logic        r_overflow;
  logic [31:0] r_shift;
  logic [39:0] r_bcd;
  logic [4:0]  r_count;

  logic        w_mode_set;
  logic        w_mode_clr;
  logic        w_start;
  logic [31:0] w_start_value;
  logic        w_load;
  logic        w_step;
  logic        w_commit;
  logic [39:0] w_bcd_adj;

  // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign w_mode_set = w_ctrl_wr && write_data[0] && !r_mode;
  assign w_mode_clr = w_ctrl_wr && !write_data[0] && r_mode;

  // A conversion starts on a DATA write in decimal mode or on entering decimal mode.
  assign w_start       = (w_data_wr && r_mode) || w_mode_set;
  assign w_start_value = w_data_wr ? w_data_merged : r_data;
  assign w_bcd_adj     = bcd_adjust(r_bcd);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath strobes. Leaving decimal mode beats a restart, and a
  // restart beats the normal progression.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_commit     = 1'b0;
    if (w_mode_clr) begin
      w_state_next = ST_IDLE;
    end else if (w_start) begin
      w_state_next = ST_CONVERT;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        ST_CONVERT: begin
          w_step = 1'b1;
          if (r_count == 5'd31) begin
            w_state_next = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // Converter datapath: load on start, then one double-dabble step per CONVERT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_shift <= w_start_value;
      r_bcd   <= '0;
      r_count <= '0;
    end else if (w_step) begin
      r_shift <= {r_shift[30:0], 1'b0};
      r_bcd   <= {w_bcd_adj[38:0], r_shift[31]};
      r_count <= r_count + 5'd1;
    end
  end

  // Mode, overflow and the digits shown on the display.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode     <= 1'b0;
      r_overflow <= 1'b0;
      r_display  <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_mode <= write_data[0];
      end
      if (w_mode_clr) begin
        r_overflow <= 1'b0;
        r_display  <= r_data;
      end else if (w_commit) begin
        r_overflow <= (r_bcd[39:32] != 8'd0);
        r_display  <= r_bcd[31:0];
      end else if (w_data_wr && !r_mode) begin
        r_display <= w_data_merged;
      end
    end
  end

  assign w_mode     = r_mode;
  assign w_overflow = r_overflow;
  assign w_busy     = (r_state != ST_IDLE);

`else

  // Hex-only build: the display mirrors every DATA write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_display <= '0;
    end else if (w_data_wr) begin
      r_display <= w_data_merged;
    end
  end

  assign w_mode     = 1'b0;
  assign w_overflow = 1'b0;
  assign w_busy     = 1'b0;

`endif

  // Register read selection, reflecting the state before the current edge.
  always_comb begin
    w_read_mux = '0;
    case (w_sel)
      ADDR_DATA:   w_read_mux = r_data;
      ADDR_CTRL:   w_read_mux = {31'd0, w_mode};
      ADDR_STATUS: w_read_mux = {30'd0, w_overflow, w_busy};
      default:     w_read_mux = '0;
    endcase
  end

  // Registered read port: returns zero on any cycle without a read strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (read_enable) begin
      r_read_data <= w_read_mux;
    end else begin
      r_read_data <= '0;
    end
  end

  assign read_data    = r_read_data;
  assign display_data = r_display;
  assign busy         = w_busy;

endmodule

// File: doc/display_7seg_controller.md
DISPLAY_7SEG_CONTROLLER -- requirements
Module: display_7seg_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port write_enable, input, 1 bit: bus write strobe, sampled each edge.
REQ-004 SHALL have port read_enable, input, 1 bit: bus read strobe, sampled each edge.
REQ-005 SHALL have port address, input, 4 bits: byte address; [3:2] selects 0=DATA, 1=CTRL, 2=STATUS, 3=reserved; [1:0] ignored.
REQ-006 SHALL have port write_data, input, 32 bits: bus write value.
REQ-007 SHALL have port write_mask, input, 4 bits: byte enables; bit n covers write_data[8n+7:8n].
REQ-008 SHALL have port read_data, output, 32 bits: registered bus read value.
REQ-009 SHALL have port display_data, output, 32 bits: eight 4-bit digit codes driven to the 7-segment interface; [3:0] is the rightmost digit.
REQ-010 SHALL have port busy, output, 1 bit: high while a decimal conversion is in progress.

Function
REQ-011 SHALL merge DATA writes per enabled byte; disabled bytes keep their old value; a write with write_mask=0000 changes nothing.
REQ-012 SHALL implement CTRL bit0 as mode (0=hex, 1=decimal), written only when write_mask[0]=1; CTRL[31:1] SHALL read 0.
REQ-013 SHALL define STATUS as bit0=busy, bit1=overflow, all other bits 0; writes to STATUS or reserved are ignored.
REQ-014 SHALL return read_data one cycle after read_enable, from the register state before that edge; read_data SHALL be 0 the cycle after read_enable=0; reserved reads return 0.
REQ-015 In hex mode, a DATA write SHALL update display_data to the merged value on the same edge.
REQ-016 In decimal mode, the FSM SHALL use states IDLE, CONVERT and COMMIT; busy=1 in CONVERT and COMMIT.
REQ-017 A start edge (DATA write in decimal mode, or a CTRL write changing mode 0->1) SHALL load the merged DATA into a 32-bit shift register, clear a 40-bit BCD accumulator and the counter, and enter CONVERT.
REQ-018 CONVERT SHALL perform one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left one bit) for exactly 32 cycles, then enter COMMIT.
REQ-019 COMMIT SHALL, within one cycle, set display_data to BCD[31:0], set overflow to (BCD[39:32]!=0), and return to IDLE.
REQ-020 Latency SHALL be: start at edge 0, display_data updated and busy low at edge 33; display_data SHALL hold its previous value until then.
REQ-021 A start edge during CONVERT or COMMIT SHALL abort and restart with the new value; the aborted result is never shown.
REQ-022 A CTRL write changing mode 1->0 SHALL abort any conversion, go to IDLE, clear overflow, and set display_data to DATA on that edge.
REQ-023 A CTRL write that leaves mode unchanged SHALL have no effect on the FSM.

Reset
REQ-024 On reset, SHALL set DATA, mode, overflow, display_data and read_data to 0, set busy to 0, and put the FSM in IDLE; reset SHALL override any simultaneous bus access and any conversion in progress.

Configuration
REQ-025 SHALL use the macro DISPLAY_7SEG_DECIMAL_EN; when it is defined, decimal mode is implemented as specified above.
REQ-026 When DISPLAY_7SEG_DECIMAL_EN is undefined, SHALL omit the FSM and converter, hold mode/busy/overflow at 0, ignore CTRL writes, and keep display_data equal to DATA.

Verification
REQ-027 Reset: assert reset during a conversion -> next cycle display_data=0, busy=0, and reads of CTRL and STATUS return 0.
REQ-028 Hex mode: write DATA=0x12345678, mask 1111 -> display_data=0x12345678 after that edge; a DATA read returns 0x12345678 one cycle later.
REQ-029 Byte mask: over 0x12345678, write 0xAABBCCDD with mask 0101 -> DATA=display_data=0x12BB56DD.
REQ-030 Decimal: CTRL=1, then write DATA=0x00BC614E -> busy high for 33 cycles, then display_data=0x12345678 and STATUS=0x0.
REQ-031 Overflow: decimal mode, write DATA=0xFFFFFFFF -> after 33 cycles display_data=0x94967295 and STATUS=0x2.
REQ-032 Restart: decimal mode, write 999, then write 42 ten cycles later -> display_data never equals 0x00000999 and equals 0x00000042 33 cycles after the second write.
